// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the 1010 sequence detectors.
// Takes WIDTH-bit words on a valid/ready handshake and emits one bit per clock
// on a/a_valid. An optional idle gap can follow each word. With GAP=0, words
// stream back to back because the next word is accepted on the last bit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no word held, in_ready=1 (unless reset is asserted)
//   S_SHIFT | head bit of the shift register is presented on a, a_valid=1
//   S_GAP   | idle spacing after a word, outputs quiet, busy=1
module serial_bit_feeder #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             a,
   output logic             a_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam bit            HAS_GAP  = (GAP > 0);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [3:0]       gcnt, gcnt_nxt;
   logic             ready_int;
   logic             accept;
   logic             last_bit;
   logic             head;
   logic [WIDTH-1:0] sreg_shifted;

   assign last_bit     = (state == S_SHIFT) && (cnt == '0);
   assign head         = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
   assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

   // The next word can be taken in IDLE. With no gap, it can also be taken on
   // the last bit of the current word so the stream has no bubble.
   assign ready_int = reset && ((state == S_IDLE) || (last_bit && !HAS_GAP));
   assign accept    = in_valid && ready_int;

   // State register and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         sreg  <= '0;
         cnt   <= '0;
         gcnt  <= '0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
         gcnt  <= gcnt_nxt;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      gcnt_nxt  = gcnt;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_SHIFT;
               sreg_nxt  = in_data;
               cnt_nxt   = CNT_LOAD;
            end
         end
         S_SHIFT: begin
            sreg_nxt = sreg_shifted;
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (HAS_GAP) begin
               state_nxt = S_GAP;
               gcnt_nxt  = GAP_LOAD;
            end else if (accept) begin
               sreg_nxt = in_data;
               cnt_nxt  = CNT_LOAD;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            if (gcnt != '0) begin
               gcnt_nxt = gcnt - 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state only; in_ready is also gated by reset
   always_comb begin
      in_ready  = ready_int;
      a_valid   = (state == S_SHIFT);
      a         = (state == S_SHIFT) && head;
      word_done = last_bit;
      busy      = (state != S_IDLE);
   end

endmodule
